serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Multi-cycle digit-serial subtractor; computes diff = a - b over WIDTH bits, SLICE_W bits per clock, with a borrow chained through a register.
- The subtract-side counterpart to the team's composed combinational adders; intended where area matters more than latency.
- valid/ready handshake on both input and output sides; one operation in flight at a time.

Parameters:
- WIDTH, 8, operand and result width in bits; must be a multiple of SLICE_W and at least SLICE_W.
- SLICE_W, 2, bits subtracted per RUN cycle.
- NSLICE (local), WIDTH/SLICE_W, number of RUN cycles.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  minuend, unsigned.
- b  input  WIDTH  subtrahend, unsigned.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer takes the result.
- diff  output  WIDTH  (a - b) mod 2^WIDTH.
- borrow  output  1  final borrow; 1 if and only if a < b (unsigned).

Behaviour:
- Reset:
  - State goes to IDLE.
  - out_valid=0, diff=0, borrow=0, slice counter=0, internal borrow=0.
  - in_ready=0 while rst is high; in_ready=1 in the first cycle after rst deasserts.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&in_ready: latch a and b into operand registers, clear the internal borrow and the counter, go to RUN.
- RUN (in_ready=0, out_valid=0): each cycle processes slice k = counter, LSB slice first.
  - {bout, d} = a[k] - b[k] - borrow_reg, computed at SLICE_W+1 bits.
  - d is written into diff bits [k*SLICE_W +: SLICE_W].
  - borrow_reg takes bout; counter increments.
  - After the cycle with k = NSLICE-1: borrow takes the final bout, go to DONE.
- DONE:
  - out_valid=1; diff and borrow are stable and held.
  - On out_ready=1: go to IDLE, out_valid=0 on the next cycle.
  - If out_ready stays low, DONE is held indefinitely with outputs unchanged.
- Latency and throughput:
  - Acceptance on edge E gives out_valid=1 after edge E+NSLICE (4 cycles for the defaults).
  - Minimum spacing between acceptances is NSLICE+2 cycles.
- in_valid outside IDLE is ignored. Inputs are not sampled, and operand registers change only on acceptance.
- diff is visible only as a qualified result; its value while out_valid=0 is don't-care to consumers. It still resets to 0.
- rst during RUN or DONE: abort immediately; the next cycle is IDLE with reset values and the in-flight result is discarded.
- Edge operands: a=b gives diff=0, borrow=0. a=0, b=2^WIDTH-1 gives diff=1, borrow=1.

Optional Feature:
- Macro: SERIAL_SUBTRACTOR_OVERFLOW_EN.
- When defined:
  - Adds output port overflow (1 bit), registered, reset 0, valid with out_valid.
  - overflow = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), i.e. two's-complement signed overflow.
  - Computed when the final slice completes and held in DONE.
- When undefined: the port does not exist and no extra logic is present.
- All other behaviour is identical in both builds.

Test Plan:
- Reset then a=200, b=55 with out_ready=1 → in_ready drops the cycle after acceptance; out_valid rises exactly 4 cycles after the accept edge with diff=145, borrow=0; back in IDLE the following cycle.
- a=5, b=10 → diff=251, borrow=1; a=0, b=255 → diff=1, borrow=1; a=b=170 → diff=0, borrow=0.
- out_ready held low 10 cycles after result → out_valid stays 1, diff and borrow unchanged; in_valid pulses with new operands are ignored; out_ready=1 → IDLE, then the new operands are accepted.
- rst asserted on the 2nd RUN cycle → next cycle out_valid=0, diff=0, borrow=0; after release, a=100, b=1 yields diff=99.
- Random 1000 pairs, WIDTH=8 and WIDTH=16 (SLICE_W=2, 4) with random valid/ready stalls → diff and borrow match the reference model; no lost or duplicated results.
- With SERIAL_SUBTRACTOR_OVERFLOW_EN: a=0x80, b=0x01 → diff=0x7F, overflow=1; a=0x7F, b=0xFF → diff=0x80, overflow=1; a=0x10, b=0x01 → overflow=0.

Source files
------------

// File: rtl/serial_subtractor.sv
// serial_subtractor: digit-serial unsigned subtractor, diff = (a - b) mod 2^WIDTH.
// Processes SLICE_W bits per clock, LSB slice first, with the borrow chained
// through a register. One operation in flight; valid/ready on both sides.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake (a, b unsigned, WIDTH bits)
//   out_valid/out_ready result handshake (diff, borrow; borrow=1 iff a < b)
//   overflow            two's-complement overflow of a - b, only when the
//                       SERIAL_SUBTRACTOR_OVERFLOW_EN macro is defined
//
// WIDTH must be a non-zero multiple of SLICE_W.
module serial_subtractor #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned SLICE_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int unsigned NSLICE = WIDTH / SLICE_W;
    localparam int unsigned CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NSLICE - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               bint_q, bint_d;     // borrow chained between slices
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               borrow_q, borrow_d;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    logic               overflow_q, overflow_d;
`endif

    logic [SLICE_W-1:0] a_slice;
    logic [SLICE_W-1:0] b_slice;
    logic [SLICE_W:0]   slice_res;          // {bout, d}

    always_comb begin
        a_slice   = a_q[cnt_q * SLICE_W +: SLICE_W];
        b_slice   = b_q[cnt_q * SLICE_W +: SLICE_W];
        // Extra top bit goes to 1 exactly when the slice result is negative.
        slice_res = {1'b0, a_slice} - {1'b0, b_slice} - {{SLICE_W{1'b0}}, bint_q};
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        bint_d   = bint_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
        overflow_d = overflow_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    cnt_d   = '0;
                    bint_d  = 1'b0;
                    state_d = StRun;
                end
            end
            StRun: begin
                diff_d[cnt_q * SLICE_W +: SLICE_W] = slice_res[SLICE_W-1:0];
                bint_d = slice_res[SLICE_W];
                if (cnt_q == LAST_SLICE) begin
                    borrow_d = slice_res[SLICE_W];
                    cnt_d    = '0;
                    state_d  = StDone;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
                    // Operand signs differ and result sign differs from a.
                    overflow_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                                 (slice_res[SLICE_W-1] != a_q[WIDTH-1]);
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            bint_q   <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
            overflow_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            bint_q   <= bint_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
            overflow_q <= overflow_d;
`endif
        end
    end

    // in_ready is held low while reset is applied.
    assign in_ready  = (state_q == StIdle) && !rst;
    assign out_valid = (state_q == StDone);
    assign diff      = diff_q;
    assign borrow    = borrow_q;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    assign overflow  = overflow_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor: two instances (8/2 and 16/4), scoreboard
// queues filled on input handshakes and drained by output monitors.
module tb_serial_subtractor;

    localparam int W0 = 8;
    localparam int S0 = 2;
    localparam int W1 = 16;
    localparam int S1 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst0, iv0, ir0, ov0, or0, br0;
    logic          rst1, iv1, ir1, ov1, or1, br1;
    logic [W0-1:0] a0, b0, d0;
    logic [W1-1:0] a1, b1, d1;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    logic          of0, of1;
`endif

    serial_subtractor #(.WIDTH(W0), .SLICE_W(S0)) u_dut0 (
        .clk(clk), .rst(rst0), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0),
        .out_valid(ov0), .out_ready(or0), .diff(d0), .borrow(br0)
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
        , .overflow(of0)
`endif
    );

    serial_subtractor #(.WIDTH(W1), .SLICE_W(S1)) u_dut1 (
        .clk(clk), .rst(rst1), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
        .out_valid(ov1), .out_ready(or1), .diff(d1), .borrow(br1)
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
        , .overflow(of1)
`endif
    );

    typedef struct packed {
        logic [15:0] d;
        logic        br;
        logic        ov;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int total = 0;
    int bad   = 0;
    int accs0 = 0, outs0 = 0, accs1 = 0, outs1 = 0;
    bit done1 = 1'b0;

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    function automatic exp_t model(input int w, input longint a, input longint b);
        longint m, sa, sb, sd;
        exp_t   e;
        m    = longint'(1) << w;
        e.d  = 16'((a - b + m) % m);
        e.br = (a < b);
        sa   = (a >= m / 2) ? a - m : a;
        sb   = (b >= m / 2) ? b - m : b;
        sd   = sa - sb;
        e.ov = (sd >= m / 2) || (sd < -(m / 2));
        return e;
    endfunction

    task automatic chk(input string nm, input longint act, input longint req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", nm, act, req);
        end
    endtask

    // Scoreboard push on accepted operands.
    always @(negedge clk) begin
        if (!rst0 && iv0 && ir0) begin
            q0.push_back(model(W0, longint'(a0), longint'(b0)));
            accs0++;
        end
        if (!rst1 && iv1 && ir1) begin
            q1.push_back(model(W1, longint'(a1), longint'(b1)));
            accs1++;
        end
    end

    // Output monitors.
    always @(negedge clk) begin
        exp_t e;
        if (!rst0 && ov0 && or0) begin
            outs0++;
            if (q0.size() == 0) begin
                total++;
                bad++;
                $display("FAIL dut0 unexpected result: got diff=%0d, none required", d0);
            end else begin
                e = q0.pop_front();
                chk("dut0 diff", longint'(d0), longint'(e.d));
                chk("dut0 borrow", longint'(br0), longint'(e.br));
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
                chk("dut0 overflow", longint'(of0), longint'(e.ov));
`endif
            end
        end
        if (!rst1 && ov1 && or1) begin
            outs1++;
            if (q1.size() == 0) begin
                total++;
                bad++;
                $display("FAIL dut1 unexpected result: got diff=%0d, none required", d1);
            end else begin
                e = q1.pop_front();
                chk("dut1 diff", longint'(d1), longint'(e.d));
                chk("dut1 borrow", longint'(br1), longint'(e.br));
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
                chk("dut1 overflow", longint'(of1), longint'(e.ov));
`endif
            end
        end
    end

    // Present operands until accepted; returns 1 ns after the accept edge.
    task automatic send0(input logic [W0-1:0] av, input logic [W0-1:0] bv);
        int n;
        @(posedge clk);
        #1;
        iv0 = 1'b1;
        a0  = av;
        b0  = bv;
        n   = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ir0 && n < 100);
        chk("dut0 accept within bound", longint'(ir0), 1);
        @(posedge clk);
        #1;
        iv0 = 1'b0;
    endtask

    task automatic drain0();
        int n;
        n = 0;
        while ((q0.size() != 0 || ov0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("dut0 drain within bound", longint'(n < 500), 1);
    endtask

    initial begin
        rst0 = 1'b1; rst1 = 1'b1;
        iv0 = 1'b0; iv1 = 1'b0;
        or0 = 1'b1; or1 = 1'b1;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset in_ready", longint'(ir0), 0);
        chk("reset out_valid", longint'(ov0), 0);
        chk("reset diff", longint'(d0), 0);
        chk("reset borrow", longint'(br0), 0);
        @(posedge clk);
        #1;
        rst0 = 1'b0;
        rst1 = 1'b0;
        @(negedge clk);
        chk("in_ready after reset", longint'(ir0), 1);

        // Second instance runs random traffic concurrently.
        fork
            begin : rand1
                int  sent1 = 0;
                int  cyc1  = 0;
                bit  acc1  = 1'b0;
                while (sent1 < 1000 && cyc1 < 60000) begin
                    @(posedge clk);
                    #1;
                    cyc1++;
                    if (acc1) iv1 = 1'b0;
                    acc1 = 1'b0;
                    or1  = ($urandom_range(0, 3) != 0);
                    if (!iv1 && $urandom_range(0, 2) == 0) begin
                        iv1 = 1'b1;
                        a1  = 16'($urandom);
                        b1  = ($urandom_range(0, 7) == 0) ? a1 : 16'($urandom);
                    end
                    @(negedge clk);
                    if (iv1 && ir1) begin
                        acc1 = 1'b1;
                        sent1++;
                    end
                end
                chk("dut1 random ops issued", sent1, 1000);
                @(posedge clk);
                #1;
                iv1 = 1'b0;
                or1 = 1'b1;
                cyc1 = 0;
                while ((q1.size() != 0 || ov1) && cyc1 < 500) begin
                    @(negedge clk);
                    cyc1++;
                end
                chk("dut1 drain within bound", longint'(cyc1 < 500), 1);
                done1 = 1'b1;
            end
        join_none

        // Latency and handshake timing on the first operation.
        send0(8'd200, 8'd55);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("out_valid low during RUN", longint'(ov0), 0);
            chk("in_ready low during RUN", longint'(ir0), 0);
        end
        @(negedge clk);
        chk("out_valid after NSLICE edges", longint'(ov0), 1);
        @(negedge clk);
        chk("out_valid drops after take", longint'(ov0), 0);
        chk("in_ready back in IDLE", longint'(ir0), 1);

        send0(8'd5, 8'd10);   drain0();
        send0(8'd0, 8'd255);  drain0();
        send0(8'd170, 8'd170); drain0();

        // Back-pressure: result held, new operands ignored until taken.
        or0 = 1'b0;
        send0(8'd9, 8'd3);
        begin : wait_valid
            int n = 0;
            while (!ov0 && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            iv0 = 1'b1;
            a0  = 8'd77;
            b0  = 8'd7;
            @(negedge clk);
            chk("hold out_valid", longint'(ov0), 1);
            chk("hold diff", longint'(d0), 6);
            chk("hold borrow", longint'(br0), 0);
            chk("hold in_ready", longint'(ir0), 0);
        end
        @(posedge clk);
        #1;
        or0 = 1'b1;
        begin : wait_accept
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!ir0 && n < 100);
            chk("pending operands accepted", longint'(ir0), 1);
        end
        @(posedge clk);
        #1;
        iv0 = 1'b0;
        drain0();

        // Reset during the second RUN cycle aborts the operation.
        send0(8'd5, 8'd10);
        drain0();
        send0(8'd100, 8'd50);
        @(posedge clk);
        #1;
        rst0 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("abort out_valid", longint'(ov0), 0);
        chk("abort diff", longint'(d0), 0);
        chk("abort borrow", longint'(br0), 0);
        chk("in_ready low in reset", longint'(ir0), 0);
        @(posedge clk);
        #1;
        rst0 = 1'b0;
        q0.delete();
        outs0 = accs0;
        @(negedge clk);
        chk("in_ready after abort", longint'(ir0), 1);
        send0(8'd100, 8'd1);
        drain0();

`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
        send0(8'h80, 8'h01); drain0();
        send0(8'h7F, 8'hFF); drain0();
        send0(8'h10, 8'h01); drain0();
`endif

        // Random traffic with stalls on both sides.
        begin : rand0
            int sent0 = 0;
            int cyc0  = 0;
            bit acc0  = 1'b0;
            while (sent0 < 1000 && cyc0 < 60000) begin
                @(posedge clk);
                #1;
                cyc0++;
                if (acc0) iv0 = 1'b0;
                acc0 = 1'b0;
                or0  = ($urandom_range(0, 3) != 0);
                if (!iv0 && $urandom_range(0, 2) == 0) begin
                    iv0 = 1'b1;
                    a0  = 8'($urandom);
                    b0  = ($urandom_range(0, 7) == 0) ? a0 : 8'($urandom);
                end
                @(negedge clk);
                if (iv0 && ir0) begin
                    acc0 = 1'b1;
                    sent0++;
                end
            end
            chk("dut0 random ops issued", sent0, 1000);
        end
        @(posedge clk);
        #1;
        iv0 = 1'b0;
        or0 = 1'b1;
        drain0();

        begin : wait_done1
            int n = 0;
            while (!done1 && n < 80000) begin
                @(negedge clk);
                n++;
            end
            chk("dut1 finished within bound", longint'(done1), 1);
        end

        chk("dut0 results vs accepts", outs0, accs0);
        chk("dut1 results vs accepts", outs1, accs1);
        chk("dut0 queue empty", q0.size(), 0);
        chk("dut1 queue empty", q1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
